cond_logic: RTL
===============

# cond_logic

Conditional-execution stage placed directly downstream of the main/ALU instruction decoder in the single-cycle ARM datapath. Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it. Gates the decoder's PCS/RegW/MemW into the datapath's PCSrc/RegWrite/MemWrite, and commits ALU flags per the decoder's 2-bit FlagW. Optionally keeps executed/skipped instruction counters for bring-up.

## Interface
Parameters:
- CNT_W, default 16, width of the performance counters (only used with COND_PERF_CNT_EN).

Ports:
- clk  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- InstrValid  in  1  current instruction is real; when 0 the stage behaves as a NOP.
- Cond  in  4  instruction bits [31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  in  2  from decoder: bit1 enables N,Z update; bit0 enables C,V update.
- PCS, RegW, MemW  in  1 each  from decoder, pre-condition.
- PCSrc, RegWrite, MemWrite  out  1 each  condition-gated controls.
- CondEx  out  1  condition passed for the current instruction.
- Flags  out  4  current registered {N,Z,C,V}.
- CntClr  in  1  synchronous clear of both counters (macro only).
- ExecCnt, SkipCnt  out  CNT_W  executed/skipped instruction counts (macro only).

## Operation
- Condition table, evaluated on the registered Flags:
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 CS C
  - 0011 CC !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 reserved, CondEx=0 (instruction skipped, never X).
- CondEx = InstrValid & table(Cond, Flags).
- PCSrc = PCS&CondEx; RegWrite = RegW&CondEx; MemWrite = MemW&CondEx.
- Flag update happens only when CondEx=1.
  - N,Z load ALUFlags[3:2] when FlagW[1]=1.
  - C,V load ALUFlags[1:0] when FlagW[0]=1.
  - The two halves are independent; a logical op with S set updates N,Z only.
- A skipped instruction never alters flags, even if FlagW is nonzero.

## Timing
- Reset (reset=0, asynchronous): Flags=4'b0000; ExecCnt=SkipCnt=0.
  - Combinational outputs follow from those values: with Flags=0 and Cond=AL, CondEx=InstrValid.
- Gating is combinational, zero latency, from the current inputs and registered Flags.
- Flags commit on the rising edge ending the instruction and are visible to the next instruction (one-cycle flag latency). There is no same-cycle bypass.
- Reset deasserting mid-stream: the first edge after release commits normally.
- Reset asserting between edges clears Flags immediately.
- InstrValid=0: all gated outputs are 0, no flag update, no counter change.

## Configuration
- Macro COND_PERF_CNT_EN.
- Defined: ExecCnt increments on every edge with InstrValid&CondEx. SkipCnt increments on every edge with InstrValid&!CondEx.
  - Both counters saturate at all-ones (no wrap).
  - CntClr=1 zeroes both on the next edge and overrides the increment in the same cycle.
- Undefined: the counters and CntClr logic are removed. ExecCnt and SkipCnt are tied to 0 and CntClr is ignored.

## Test plan
- Reset, then Cond=EQ, RegW=1, InstrValid=1 -> RegWrite=0 (Z=0 after reset). Flags=0000.
- SUBS equal operands: Cond=AL, FlagW=11, ALUFlags=0110, edge; next Cond=EQ, RegW=1 -> RegWrite=1, Flags=0110.
- ANDS: Flags=0110, FlagW=10, ALUFlags=1000, edge -> Flags=1010 (C,V preserved).
- Conditional skip with S bit: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0, Flags stay 0000 after the edge.
- Full sweep: all 16 Flags values × all 16 Cond codes against the table; Cond=1111 always gives CondEx=0.
- With COND_PERF_CNT_EN and CNT_W=4:
  - 20 executed instructions -> ExecCnt=15 (saturated).
  - CntClr together with an executed instruction -> ExecCnt=0 after the edge.
  - reset low mid-run -> both counters 0 immediately.

Source files
------------

// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage of the single-cycle ARM datapath.
// It holds the architectural NZCV flag register and evaluates the
// instruction's condition field against it. The decoder's PCS/RegW/MemW are
// gated by the result, and ALU flags are committed under FlagW control.
//
// Optional feature: define COND_PERF_CNT_EN to build the executed/skipped
// instruction counters. Without it ExecCnt/SkipCnt are tied to 0 and CntClr
// is ignored.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears flags and counters
//   InstrValid  current instruction is real (0 behaves as a NOP)
//   Cond        condition field, instruction bits [31:28]
//   ALUFlags    {N,Z,C,V} produced by the ALU for this instruction
//   FlagW       bit1 enables N,Z update; bit0 enables C,V update
//   PCS/RegW/MemW            decoder controls before condition gating
//   PCSrc/RegWrite/MemWrite  condition-gated controls
//   CondEx      condition passed for the current instruction
//   Flags       registered {N,Z,C,V}
//   CntClr      synchronous clear of both counters
//   ExecCnt     saturating count of executed instructions
//   SkipCnt     saturating count of skipped instructions
module cond_logic #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  input  logic             CntClr,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
);

  logic [3:0] flags_q, flags_d;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_pass;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition table on the registered flags; 1111 is reserved and never passes.
  always_comb begin
    cond_pass = 1'b0;
    unique case (Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondEx   = InstrValid & cond_pass;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;
  assign Flags    = flags_q;

  // N,Z and C,V halves commit independently, only for executed instructions.
  always_comb begin
    flags_d = flags_q;
    if (CondEx) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (CntClr) begin
      exec_d = '0;
      skip_d = '0;
    end else if (InstrValid) begin
      if (CondEx) begin
        if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
      end else begin
        if (skip_q != '1) skip_d = skip_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign ExecCnt = exec_q;
  assign SkipCnt = skip_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = CntClr;
  assign ExecCnt        = '0;
  assign SkipCnt        = '0;
`endif

endmodule
